radiation_histogram_multi: RTL
==============================

Name: radiation_histogram_multi

Overview:
Parametrised successor to the single-channel hardware-accelerated histogram in the radiation receiver path. It accepts energy-tagged events from up to CHANNELS radiation processors and accumulates one histogram per channel in internal storage. Updates use a pipelined read-modify-write with hazard forwarding. The block has a bus-facing read port and a self-timed clear sweep. It sits between the radiation processor outputs and the AXI4-Lite slave register file.

Parameters:
CHANNELS, 4, number of independent histograms (>=1)
BIN_BITS, 8, log2 of bins per channel; bin index = eventEnergy[ENERGY_WIDTH-1 -: BIN_BITS]
ENERGY_WIDTH, 12, event energy width (>= BIN_BITS)
COUNT_WIDTH, 16, bin counter width
CH_BITS, (CHANNELS>1 ? $clog2(CHANNELS) : 1), derived channel index width

Ports:
clk  in  1  system clock, 100 MHz
rstn  in  1  reset; synchronous, active-low
enable  in  1  1 = accept events; 0 = eventReady held low
eventValid  in  1  event present
eventReady  out  1  event accepted when eventValid & eventReady
eventChannel  in  CH_BITS  source channel; values >= CHANNELS are dropped
eventEnergy  in  ENERGY_WIDTH  event energy
readEn  in  1  single-cycle read request
readChannel  in  CH_BITS  channel to read
readBin  in  BIN_BITS  bin to read
readValid  out  1  pulses 1 cycle after readEn
readValue  out  COUNT_WIDTH  bin contents
clearStart  in  1  request zeroing of all bins
clearBusy  out  1  clear sweep in progress
droppedEvents  out  16  count of accepted events with invalid channel; saturates at 0xFFFF

Behaviour:
- Storage: CHANNELS*2^BIN_BITS words of COUNT_WIDTH. Address = {channel, bin}. The array itself has no reset.
- On rstn=0: eventReady=0, readValid=0, readValue=0, droppedEvents=0, pipeline valids=0, state=CLEAR, sweep address=0, clearBusy=1.
- States:
  - RUN: eventReady = enable.
  - DRAIN: eventReady=0. Waits until the S1/S2 pipeline is empty, then goes to CLEAR.
  - CLEAR: writes 0 to one address per cycle, from 0 to the last address. Enters RUN on the cycle after the last write. clearBusy=1 in DRAIN and CLEAR.
- RUN -> DRAIN on clearStart=1. clearStart is ignored while clearBusy=1.
- After reset, the full sweep takes exactly CHANNELS*2^BIN_BITS cycles before eventReady can go high.
- Update pipeline:
  - S0: handshake; latch address.
  - S1: read old count.
  - S2: write old+1.
  - Latency: an accepted event is visible to a read issued 3 cycles after acceptance.
  - Sustained throughput: 1 event per cycle.
- Hazards: if the S1 address equals the S2 address, S1 uses the S2 write data instead of the array output. Back-to-back events to the same bin must therefore count exactly.
- Invalid channel: the handshake still completes, the array is untouched, and droppedEvents increments.
- Counter overflow (macro absent): the counter wraps 0xFFFF -> 0x0000.
- Reads:
  - readValue is registered and readValid=1 the cycle after readEn.
  - If S2 writes the same address in the readEn cycle, the pre-write value is returned.
  - Reads during a clear return the current array contents (either old or zero); no error is flagged.
  - An out-of-range readChannel returns 0.
- Reset mid-operation: discards in-flight pipeline events and restarts the sweep from address 0.
- Deasserting enable mid-stream: events already in S1/S2 complete normally.

Optional Feature:
HISTOGRAM_SATURATE_EN
- Defined: counters saturate at 2^COUNT_WIDTH-1. Adds output port saturatedAny (1 bit): sticky, set when any bin hits saturation. It is cleared by reset and at the start of a clear sweep.
- Not defined: counters wrap, and the saturatedAny port does not exist.

Test Plan:
- Release reset -> clearBusy=1 for exactly 1024 cycles (defaults), then eventReady=1 with enable=1. Reading ch2/bin5 returns 0.
- 10 back-to-back events ch1, energy 0x3A7 (bin 0x3A), no gaps -> read ch1/bin 0x3A returns 10. Adjacent bins 0x39 and 0x3B return 0.
- Interleaved events ch0/bin0, ch0/bin0, ch3/bin0, ch0/bin0 on consecutive cycles -> ch0/bin0=3, ch3/bin0=1, confirming forwarding.
- Preload ch0/bin7 to 0xFFFF via 65535 events, then 1 more -> without macro reads 0x0000; with macro reads 0xFFFF and saturatedAny=1.
- With CHANNELS=3, an event on eventChannel=3 -> handshake completes, droppedEvents=1, all valid bins unchanged.
- Pulse clearStart with an event in S1 -> the event completes, DRAIN lasts <=2 cycles, and after the sweep all bins read 0. Assert rstn=0 for 1 cycle mid-sweep -> the sweep restarts and takes the full 1024 cycles.

Source files
------------

// File: rtl/radiation_histogram_multi.sv
// Multi-channel energy histogram: pipelined read-modify-write update with forwarding,
// registered bus read port and self-timed clear sweep. Optional macro: HISTOGRAM_SATURATE_EN.
module radiation_histogram_multi #(
  parameter int CHANNELS     = 4,
  parameter int BIN_BITS     = 8,
  parameter int ENERGY_WIDTH = 12,
  parameter int COUNT_WIDTH  = 16,
  parameter int CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic                    eventValid,
  output logic                    eventReady,
  input  logic [CH_BITS-1:0]      eventChannel,
  input  logic [ENERGY_WIDTH-1:0] eventEnergy,
  input  logic                    readEn,
  input  logic [CH_BITS-1:0]      readChannel,
  input  logic [BIN_BITS-1:0]     readBin,
  output logic                    readValid,
  output logic [COUNT_WIDTH-1:0]  readValue,
  input  logic                    clearStart,
  output logic                    clearBusy,
`ifdef HISTOGRAM_SATURATE_EN
  output logic                    saturatedAny,
`endif
  output logic [15:0]             droppedEvents
);

  localparam int ADDR_W = CH_BITS + BIN_BITS;
  localparam int DEPTH  = CHANNELS * (2 ** BIN_BITS);
  localparam logic [ADDR_W-1:0]      LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CH_BITS:0]       CH_LIMIT  = (CH_BITS + 1)'(CHANNELS);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      sweep_q, sweep_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]      s1_addr_q, s1_addr_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0]      s2_addr_q, s2_addr_d;
  logic [COUNT_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                   read_valid_q, read_valid_d;
  logic [COUNT_WIDTH-1:0] read_value_q, read_value_d;
  logic [15:0]            dropped_q, dropped_d;
`ifdef HISTOGRAM_SATURATE_EN
  logic                   sat_q, sat_d;
`endif

  logic                   accept, ev_ch_ok, rd_ch_ok;
  logic [COUNT_WIDTH-1:0] s1_old, s1_new;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_waddr;
  logic [COUNT_WIDTH-1:0] mem_wdata;

  logic [COUNT_WIDTH-1:0] mem [DEPTH];

  if (ENERGY_WIDTH > BIN_BITS) begin : g_energy_lsb
    logic unused_energy_lsb;
    assign unused_energy_lsb = ^eventEnergy[ENERGY_WIDTH-BIN_BITS-1:0];
  end

  assign eventReady    = (state_q == ST_RUN) & enable;
  assign clearBusy     = (state_q != ST_RUN);
  assign readValid     = read_valid_q;
  assign readValue     = read_value_q;
  assign droppedEvents = dropped_q;
`ifdef HISTOGRAM_SATURATE_EN
  assign saturatedAny  = sat_q;
`endif

  // Mode sequencing; DRAIN only waits for S1 because S2 retires on the same edge
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_RUN: begin
        if (clearStart) state_d = ST_DRAIN;
        else            state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (!s1_valid_q) begin
          state_d = ST_CLEAR;
          sweep_d = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        if (sweep_q == LAST_ADDR) begin
          state_d = ST_RUN;
          sweep_d = {ADDR_W{1'b0}};
        end else begin
          sweep_d = sweep_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_CLEAR;
        sweep_d = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Update pipeline: handshake, forwarded read of the old count, increment
  always_comb begin
    accept     = eventValid & eventReady;
    ev_ch_ok   = ({1'b0, eventChannel} < CH_LIMIT);
    s1_valid_d = accept & ev_ch_ok;
    s1_addr_d  = {eventChannel, eventEnergy[ENERGY_WIDTH-1 -: BIN_BITS]};
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) s1_old = s2_data_q;
    else                                        s1_old = mem[s1_addr_q];
`ifdef HISTOGRAM_SATURATE_EN
    if (s1_old == COUNT_MAX) s1_new = COUNT_MAX;
    else                     s1_new = s1_old + COUNT_WIDTH'(1);
`else
    s1_new = s1_old + COUNT_WIDTH'(1);
`endif
    s2_valid_d = s1_valid_q;
    s2_addr_d  = s1_addr_q;
    s2_data_d  = s1_new;
    if (accept && !ev_ch_ok && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
    else                                                 dropped_d = dropped_q;
`ifdef HISTOGRAM_SATURATE_EN
    if ((state_q == ST_DRAIN) && !s1_valid_q)        sat_d = 1'b0;
    else if (s1_valid_q && (s1_new == COUNT_MAX))    sat_d = 1'b1;
    else                                             sat_d = sat_q;
`endif
  end

  // Bus read port; out-of-range channels read as zero
  always_comb begin
    rd_ch_ok     = ({1'b0, readChannel} < CH_LIMIT);
    read_valid_d = readEn;
    read_value_d = read_value_q;
    if (readEn) begin
      if (rd_ch_ok) read_value_d = mem[{readChannel, readBin}];
      else          read_value_d = {COUNT_WIDTH{1'b0}};
    end else begin
      read_value_d = read_value_q;
    end
  end

  // Single array write port shared by the sweep and the S2 stage
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s2_addr_q;
    mem_wdata = s2_data_q;
    if (!rstn) begin
      mem_we = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_q;
      mem_wdata = {COUNT_WIDTH{1'b0}};
    end else if (s2_valid_q) begin
      mem_we = 1'b1;
    end else begin
      mem_we = 1'b0;
    end
  end

  // Control, pipeline and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_CLEAR;
      sweep_q      <= {ADDR_W{1'b0}};
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= {ADDR_W{1'b0}};
      s2_valid_q   <= 1'b0;
      s2_addr_q    <= {ADDR_W{1'b0}};
      s2_data_q    <= {COUNT_WIDTH{1'b0}};
      read_valid_q <= 1'b0;
      read_value_q <= {COUNT_WIDTH{1'b0}};
      dropped_q    <= 16'h0000;
`ifdef HISTOGRAM_SATURATE_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s2_valid_q   <= s2_valid_d;
      s2_addr_q    <= s2_addr_d;
      s2_data_q    <= s2_data_d;
      read_valid_q <= read_valid_d;
      read_value_q <= read_value_d;
      dropped_q    <= dropped_d;
`ifdef HISTOGRAM_SATURATE_EN
      sat_q        <= sat_d;
`endif
    end
  end

  // Histogram storage, deliberately without reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
